wb_timeout_bridge: RTL and testbench

Single-outstanding Wishbone (classic) bridge between the wb_host master port and the downstream interconnect/slaves.
- Registers each request and forwards it to the slave side.
- Returns the slave's ack/err and read data to the master.
- Aborts any slave access that does not respond within a programmable bound, answering the master with an error and a poison data word, so a hung peripheral cannot stall the management SoC or RISC-V boot.
- Keeps sticky timeout status for firmware/debug.

---
 rtl/wb_timeout_bridge_pkg.sv | 21 ++
 rtl/wb_to_status.sv | 57 +++++
 rtl/wb_timeout_bridge.sv | 171 +++++++++++++++++
 tb/tb_wb_timeout_bridge.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_timeout_bridge_pkg.sv
// Shared definitions for the Wishbone timeout bridge: FSM encoding,
// default widths, the poison word and a saturating increment helper.
package wb_timeout_bridge_pkg;

  localparam int          WB_AW_DEF   = 32;
  localparam int          WB_DW_DEF   = 32;
  localparam int          TO_W_DEF    = 8;
  localparam logic [31:0] POISON_DEF  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Increment an 8-bit status count, sticking at its maximum value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/wb_to_status.sv
// Sticky timeout status: saturating timeout count, address of the most
// recent timed-out access and a flag. A timeout event beats a clear.
module wb_to_status
  import wb_timeout_bridge_pkg::*;
#(
  parameter int AW = WB_AW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          to_pulse_i,
  input  logic [AW-1:0] to_adr_i,
  output logic [7:0]    to_count_o,
  output logic [AW-1:0] to_adr_o,
  output logic          to_flag_o
);

  logic [7:0]    count_q, count_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          flag_q, flag_d;

  // Next status: a timeout records itself (counting from zero if cleared now).
  always_comb begin
    count_d = count_q;
    adr_d   = adr_q;
    flag_d  = flag_q;
    if (to_pulse_i) begin
      count_d = clr_i ? 8'd1 : sat_inc8(count_q);
      adr_d   = to_adr_i;
      flag_d  = 1'b1;
    end else if (clr_i) begin
      count_d = 8'd0;
      adr_d   = {AW{1'b0}};
      flag_d  = 1'b0;
    end else begin
      count_d = count_q;
    end
  end

  // Status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 8'd0;
      adr_q   <= {AW{1'b0}};
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      adr_q   <= adr_d;
      flag_q  <= flag_d;
    end
  end

  assign to_count_o = count_q;
  assign to_adr_o   = adr_q;
  assign to_flag_o  = flag_q;

endmodule

// File: rtl/wb_timeout_bridge.sv
// Single-outstanding Wishbone classic bridge. Every request is registered
// toward the slave; a slave that stays silent for TIMEOUT cycles is
// abandoned and the master gets an error with a poison data word.
module wb_timeout_bridge
  import wb_timeout_bridge_pkg::*;
#(
  parameter int            AW      = WB_AW_DEF,
  parameter int            DW      = WB_DW_DEF,
  parameter int            TO_W    = TO_W_DEF,
  parameter int            TIMEOUT = 255,
  parameter logic [DW-1:0] POISON  = DW'(POISON_DEF)
) (
  input  logic            mclk,
  input  logic            h_reset_n,
  input  logic            wbm_cyc_i,
  input  logic            wbm_stb_i,
  input  logic            wbm_we_i,
  input  logic [AW-1:0]   wbm_adr_i,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic [DW/8-1:0] wbm_sel_i,
  output logic [DW-1:0]   wbm_dat_o,
  output logic            wbm_ack_o,
  output logic            wbm_err_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic            wbs_we_o,
  output logic [AW-1:0]   wbs_adr_o,
  output logic [DW-1:0]   wbs_dat_o,
  output logic [DW/8-1:0] wbs_sel_o,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic            wbs_ack_i,
  input  logic            wbs_err_i,
  input  logic            clr_status_i,
  output logic [7:0]      to_count_o,
  output logic [AW-1:0]   to_adr_o,
  output logic            to_flag_o
);

  // Counter value seen on the edge that completes TIMEOUT strobe cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              wbs_req_q, wbs_req_d;
  logic              wbs_we_q, wbs_we_d;
  logic [AW-1:0]     wbs_adr_q, wbs_adr_d;
  logic [DW-1:0]     wbs_dat_q, wbs_dat_d;
  logic [DW/8-1:0]   wbs_sel_q, wbs_sel_d;
  logic [DW-1:0]     wbm_dat_q, wbm_dat_d;
  logic              wbm_ack_q, wbm_ack_d;
  logic              wbm_err_q, wbm_err_d;
  logic              to_pulse_s;

  // Next-state and response decode; ack/err default low so they pulse once.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wbs_req_d  = wbs_req_q;
    wbs_we_d   = wbs_we_q;
    wbs_adr_d  = wbs_adr_q;
    wbs_dat_d  = wbs_dat_q;
    wbs_sel_d  = wbs_sel_q;
    wbm_dat_d  = wbm_dat_q;
    wbm_ack_d  = 1'b0;
    wbm_err_d  = 1'b0;
    to_pulse_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          wbs_we_d  = wbm_we_i;
          wbs_adr_d = wbm_adr_i;
          wbs_dat_d = wbm_dat_i;
          wbs_sel_d = wbm_sel_i;
          wbs_req_d = 1'b1;
          cnt_d     = {TO_W{1'b0}};
          state_d   = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!wbm_cyc_i) begin
          // Master abandoned the cycle: withdraw silently.
          wbs_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (wbs_ack_i) begin
          if (!wbs_we_q) begin
            wbm_dat_d = wbs_dat_i;
          end else begin
            wbm_dat_d = wbm_dat_q;
          end
          wbm_ack_d = 1'b1;
          wbs_req_d = 1'b0;
          state_d   = ST_RESP;
        end else if (wbs_err_i) begin
          wbm_err_d = 1'b1;
          wbm_dat_d = {DW{1'b0}};
          wbs_req_d = 1'b0;
          state_d   = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          wbm_err_d  = 1'b1;
          wbm_dat_d  = POISON;
          wbs_req_d  = 1'b0;
          to_pulse_s = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_RESP: begin
        // Request is deliberately not resampled here to avoid a double issue.
        state_d = ST_IDLE;
      end
      default: begin
        wbs_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {TO_W{1'b0}};
      wbs_req_q <= 1'b0;
      wbs_we_q  <= 1'b0;
      wbs_adr_q <= {AW{1'b0}};
      wbs_dat_q <= {DW{1'b0}};
      wbs_sel_q <= {(DW/8){1'b0}};
      wbm_dat_q <= {DW{1'b0}};
      wbm_ack_q <= 1'b0;
      wbm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wbs_req_q <= wbs_req_d;
      wbs_we_q  <= wbs_we_d;
      wbs_adr_q <= wbs_adr_d;
      wbs_dat_q <= wbs_dat_d;
      wbs_sel_q <= wbs_sel_d;
      wbm_dat_q <= wbm_dat_d;
      wbm_ack_q <= wbm_ack_d;
      wbm_err_q <= wbm_err_d;
    end
  end

  wb_to_status #(
    .AW (AW)
  ) u_status (
    .clk_i      (mclk),
    .rst_ni     (h_reset_n),
    .clr_i      (clr_status_i),
    .to_pulse_i (to_pulse_s),
    .to_adr_i   (wbs_adr_q),
    .to_count_o (to_count_o),
    .to_adr_o   (to_adr_o),
    .to_flag_o  (to_flag_o)
  );

  assign wbs_cyc_o = wbs_req_q;
  assign wbs_stb_o = wbs_req_q;
  assign wbs_we_o  = wbs_we_q;
  assign wbs_adr_o = wbs_adr_q;
  assign wbs_dat_o = wbs_dat_q;
  assign wbs_sel_o = wbs_sel_q;
  assign wbm_dat_o = wbm_dat_q;
  assign wbm_ack_o = wbm_ack_q;
  assign wbm_err_o = wbm_err_q;

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Randomised bench for wb_timeout_bridge with a queue-based scoreboard.
module tb_wb_timeout_bridge;

  localparam int          TMO      = 16;
  localparam logic [31:0] POISON_V = 32'hDEAD_BEEF;
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3;

  logic        mclk, h_reset_n;
  logic        wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
  logic [3:0]  wbm_sel_i, wbs_sel_o;
  logic        wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i, to_adr_o;
  logic        wbs_ack_i, wbs_err_i, clr_status_i, to_flag_o;
  logic [7:0]  to_count_o;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic [7:0]  cnt;
    logic        flag;
    logic [31:0] tadr;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference state: last master data, status count/flag/address.
  logic [31:0] m_dat  = 32'd0;
  logic [7:0]  m_cnt  = 8'd0;
  logic        m_flag = 1'b0;
  logic [31:0] m_tadr = 32'd0;

  wb_timeout_bridge #(.TIMEOUT(TMO)) dut (
    .mclk(mclk), .h_reset_n(h_reset_n),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .clr_status_i(clr_status_i), .to_count_o(to_count_o),
    .to_adr_o(to_adr_o), .to_flag_o(to_flag_o)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, 64'({wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o, wbs_we_o,
                           wbs_sel_o, to_flag_o, to_count_o}), 64'd0);
    chk({nm, "_wbm_dat"}, 64'(wbm_dat_o), 64'd0);
    chk({nm, "_wbs_adr_dat"}, {wbs_adr_o, wbs_dat_o}, 64'd0);
    chk({nm, "_to_adr"}, 64'(to_adr_o), 64'd0);
  endtask

  task automatic model_reset();
    m_dat = 32'd0; m_cnt = 8'd0; m_flag = 1'b0; m_tadr = 32'd0;
  endtask

  task automatic master_req(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_we_i = we;
    wbm_adr_i = adr; wbm_dat_i = dat; wbm_sel_i = sel;
  endtask

  task automatic master_idle();
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_we_i = 1'b0;
    wbm_adr_i = $urandom; wbm_dat_i = $urandom; wbm_sel_i = 4'h0;
  endtask

  // One complete access; the slave answers (kind) so that the bridge samples
  // it on the lat-th edge after the strobe rose. lat > TMO means it never does.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int kind, input int lat,
                      input logic [31:0] rdata, input logic clr_end);
    exp_t e;
    int   n;
    int   end_k;
    logic to;
    logic seen;
    to    = (kind == K_NONE) || (lat > TMO);
    end_k = to ? TMO : lat;
    e.ack = !to && (kind == K_ACK || kind == K_BOTH);
    e.err = !e.ack;
    if (e.ack) e.dat = we ? m_dat : rdata;
    else if (to) e.dat = POISON_V;
    else e.dat = 32'd0;
    m_dat = e.dat;
    if (to) begin
      m_cnt  = clr_end ? 8'd1 : ((m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1);
      m_flag = 1'b1;
      m_tadr = adr;
    end else if (clr_end) begin
      m_cnt = 8'd0; m_flag = 1'b0; m_tadr = 32'd0;
    end
    e.cnt = m_cnt; e.flag = m_flag; e.tadr = m_tadr;
    sb_q.push_back(e);

    master_req(we, adr, dat, sel);
    @(posedge mclk); #1;
    chk("stb_rise", 64'({wbs_cyc_o, wbs_stb_o}), 64'd3);
    chk("wbs_adr", 64'(wbs_adr_o), 64'(adr));
    chk("wbs_dat", 64'(wbs_dat_o), 64'(dat));
    chk("wbs_we_sel", 64'({wbs_we_o, wbs_sel_o}), 64'({we, sel}));
    n = 1;
    seen = 1'b0;
    for (int k = 1; k <= TMO + 2; k++) begin
      if (k == lat && kind != K_NONE) begin
        wbs_ack_i = (kind != K_ERR);
        wbs_err_i = (kind != K_ACK);
        wbs_dat_i = rdata;
      end
      if (k == end_k && clr_end) clr_status_i = 1'b1;
      @(posedge mclk); #1;
      wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_dat_i = $urandom; clr_status_i = 1'b0;
      if (wbs_stb_o) n++;
      else begin
        seen = wbm_ack_o || wbm_err_o;
        break;
      end
    end
    chk("stb_cycles", 64'(n), 64'(end_k));
    chk("resp_with_stb_drop", 64'(seen), 64'd1);
    master_idle();
    @(posedge mclk); #1;
  endtask

  task automatic clear_status();
    clr_status_i = 1'b1;
    @(posedge mclk); #1;
    clr_status_i = 1'b0;
    model_reset_status();
    chk("clr_count", 64'(to_count_o), 64'd0);
    chk("clr_flag_adr", 64'({to_flag_o, to_adr_o}), 64'd0);
  endtask

  task automatic model_reset_status();
    m_cnt = 8'd0; m_flag = 1'b0; m_tadr = 32'd0;
  endtask

  // Scoreboard monitor: every master response must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge mclk);
      if (h_reset_n && (wbm_ack_o || wbm_err_o)) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 64'({wbm_ack_o, wbm_err_o}), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("resp_ack_err", 64'({wbm_ack_o, wbm_err_o}), 64'({e.ack, e.err}));
          chk("resp_dat", 64'(wbm_dat_o), 64'(e.dat));
          chk("to_count", 64'(to_count_o), 64'(e.cnt));
          chk("to_flag_adr", 64'({to_flag_o, to_adr_o}), 64'({e.flag, e.tadr}));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    h_reset_n = 1'b0; clr_status_i = 1'b0;
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_dat_i = 32'd0;
    master_idle();
    #23;
    chk_all_zero("reset");
    h_reset_n = 1'b1;
    @(posedge mclk); #1;
    chk_all_zero("post_reset");

    // Directed cases.
    xfer(1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF, K_ACK, 2, 32'h0, 1'b0);
    xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, K_ACK, 3, 32'hA5A5_5A5A, 1'b0);
    chk("read_hold", 64'(wbm_dat_o), 64'h0000_0000_A5A5_5A5A);
    xfer(1'b0, 32'h3080_0000, 32'h0, 4'hF, K_NONE, 0, 32'h0, 1'b0);
    xfer(1'b0, 32'h3000_0030, 32'h0, 4'h3, K_BOTH, 4, 32'h0BAD_F00D, 1'b0);
    xfer(1'b0, 32'h3000_0040, 32'h0, 4'hF, K_ACK, TMO, 32'h1111_2222, 1'b0);
    xfer(1'b1, 32'h3000_0050, 32'hCAFE_0001, 4'h1, K_ERR, 5, 32'h7777_7777, 1'b0);

    // Master abort three cycles into the request.
    master_req(1'b0, 32'h3000_0060, 32'h0, 4'hF);
    @(posedge mclk); #1;
    chk("abort_stb_rise", 64'(wbs_stb_o), 64'd1);
    repeat (2) @(posedge mclk);
    #1;
    master_idle();
    @(posedge mclk); #1;
    chk("abort_drop", 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);
    chk("abort_no_resp", 64'({wbm_ack_o, wbm_err_o}), 64'd0);
    @(posedge mclk); #1;
    xfer(1'b0, 32'h3000_0070, 32'h0, 4'hF, K_ACK, 1, 32'h5555_AAAA, 1'b0);

    clear_status();
    xfer(1'b0, 32'h3080_0004, 32'h0, 4'hF, K_NONE, 0, 32'h0, 1'b0);
    xfer(1'b0, 32'h3080_0008, 32'h0, 4'hF, K_NONE, 0, 32'h0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)), int'($urandom_range(1, TMO + 2)), $urandom,
           1'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 9) == 0) clear_status();
    end

    // Saturation of the timeout count.
    clear_status();
    for (int i = 0; i < 257; i++) begin
      xfer(1'b0, 32'h3100_0000 + 32'(i), 32'h0, 4'hF, K_NONE, 0, 32'h0, 1'b0);
    end
    chk("sat_count", 64'(to_count_o), 64'd255);
    clear_status();
    xfer(1'b1, 32'h3200_0000, 32'h0102_0304, 4'hF, K_NONE, 0, 32'h0, 1'b0);

    // Asynchronous reset in the middle of a request.
    master_req(1'b1, 32'h3300_0000, 32'hFFFF_FFFF, 4'hF);
    @(posedge mclk); #1;
    chk("rst_req_stb", 64'(wbs_stb_o), 64'd1);
    repeat (2) @(posedge mclk);
    #3;
    h_reset_n = 1'b0;
    #1;
    chk_all_zero("mid_req_reset");
    master_idle();
    model_reset();
    @(posedge mclk); #2;
    h_reset_n = 1'b1;
    @(posedge mclk); #1;
    chk_all_zero("after_mid_reset");
    xfer(1'b0, 32'h3000_0080, 32'h0, 4'hF, K_ACK, 2, 32'h600D_600D, 1'b0);

    for (int w = 0; w < 50 && sb_q.size() != 0; w++) @(posedge mclk);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
